// File: rtl/axis_rr_arbiter_4to1.sv
`default_nettype none
// ============================================================================
// Module      : axis_rr_arbiter_4to1
// Description : Four-input, packet-locked round-robin arbiter onto a single
//               AXI-Stream sink. One requester is granted at a time and keeps
//               the grant until its last beat is accepted. Accepted beats go
//               through one output register stage.
// Ports       : clk, reset (async, active-high)
//               s_valid[3:0], s_data[4*DATA_W-1:0], s_last[3:0] : requesters
//               s_ready[3:0]                        : per-requester ready
//               m_valid, m_data[DATA_W-1:0], m_last : registered output beat
//               m_ready                             : downstream ready
//               grant[3:0] (one-hot, 0 when idle), busy (packet locked)
// Revision    : 1.0 - initial release
// ============================================================================
module axis_rr_arbiter_4to1 #(
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            s_valid,
   input  logic [4*DATA_W-1:0]   s_data,
   input  logic [3:0]            s_last,
   output logic [3:0]            s_ready,
   output logic                  m_valid,
   output logic [DATA_W-1:0]     m_data,
   output logic                  m_last,
   input  logic                  m_ready,
   output logic [3:0]            grant,
   output logic                  busy
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_LOCK = 1'b1;

   logic [0:0]        state_q,   state_d;
   logic [1:0]        gidx_q,    gidx_d;
   logic [1:0]        ptr_q,     ptr_d;
   logic [3:0]        grant_q,   grant_d;
   logic              m_valid_q, m_valid_d;
   logic [DATA_W-1:0] m_data_q,  m_data_d;
   logic              m_last_q,  m_last_d;

   logic              out_free;
   logic              accept;
   logic [1:0]        sel_idx;
   logic              sel_found;
   logic [1:0]        cand;

   // Output register can take a new beat when empty or being drained now;
   // this is what makes s_ready combinationally follow m_ready.
   assign out_free = !m_valid_q || m_ready;
   assign accept   = (state_q == ST_LOCK) && s_valid[gidx_q] && out_free;

   // Rotating-priority search starting at ptr_q.
   always_comb begin
      sel_idx   = ptr_q;
      sel_found = 1'b0;
      cand      = ptr_q;
      for (int k = 0; k < 4; k++) begin
         cand = ptr_q + 2'(k);
         if (!sel_found && s_valid[cand]) begin
            sel_idx   = cand;
            sel_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      gidx_d    = gidx_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_last_d  = m_last_q;

      case (state_q)
         ST_IDLE: begin
            if (sel_found) begin
               gidx_d  = sel_idx;
               grant_d = 4'b0001 << sel_idx;
               state_d = ST_LOCK;
            end
         end
         default: begin
            // Only an accepted last beat releases the lock; the finished
            // requester drops to lowest priority.
            if (accept && s_last[gidx_q]) begin
               state_d = ST_IDLE;
               grant_d = 4'b0000;
               ptr_d   = gidx_q + 2'd1;
            end
         end
      endcase

      if (accept) begin
         m_valid_d = 1'b1;
         m_data_d  = s_data[gidx_q*DATA_W +: DATA_W];
         m_last_d  = s_last[gidx_q];
      end else if (m_valid_q && m_ready) begin
         m_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         gidx_q    <= 2'd0;
         ptr_q     <= 2'd0;
         grant_q   <= 4'b0000;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_last_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         gidx_q    <= gidx_d;
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_last_q  <= m_last_d;
      end
   end

   // grant_q is the one-hot decode of gidx_q while locked, so it doubles as
   // the ready mask.
   assign s_ready = ((state_q == ST_LOCK) && out_free) ? grant_q : 4'b0000;
   assign grant   = grant_q;
   assign busy    = (state_q == ST_LOCK);
   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign m_last  = m_last_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_rr_arbiter_4to1.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_rr_arbiter_4to1
// Description : Directed self-checking bench for axis_rr_arbiter_4to1.
//               Inputs change 1 time unit after a rising edge; outputs are
//               sampled 1 time unit later, well clear of the next edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_rr_arbiter_4to1;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  s_valid;
   logic [31:0] s_data;
   logic [3:0]  s_last;
   logic [3:0]  s_ready;
   logic        m_valid;
   logic [7:0]  m_data;
   logic        m_last;
   logic        m_ready;
   logic [3:0]  grant;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   axis_rr_arbiter_4to1 #(.DATA_W(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .s_valid (s_valid),
      .s_data  (s_data),
      .s_last  (s_last),
      .s_ready (s_ready),
      .m_valid (m_valid),
      .m_data  (m_data),
      .m_last  (m_last),
      .m_ready (m_ready),
      .grant   (grant),
      .busy    (busy)
   );

   initial forever #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int i, input logic [7:0] d, input logic l);
      s_data[i*8 +: 8] = d;
      s_last[i]        = l;
   endtask

   task automatic do_reset;
      reset   = 1'b1;
      s_valid = 4'b0000;
      step();
      reset   = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; s_valid = 4'b0000; s_data = '0; s_last = 4'b0000; m_ready = 1'b1;
      step(); step();
      n_checks++; if ({m_valid, m_data, m_last} !== 10'd0) begin n_fail++; $display("FAIL rst_out: got v=%b d=%h l=%b want all 0", m_valid, m_data, m_last); end
      n_checks++; if ({grant, busy, s_ready} !== 9'd0) begin n_fail++; $display("FAIL rst_ctl: got grant=%b busy=%b s_ready=%b want 0", grant, busy, s_ready); end
      reset = 1'b0;
      s_valid = 4'b0010; set_lane(1, 8'h11, 1'b0);
      #1;
      n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rst_idle_c0: got grant=%b want 0000", grant); end
      step();
      n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL rst_pre_grant: got %b want 0010", grant); end
      step();
      n_checks++; if (m_valid !== 1'b1 || m_data !== 8'h11) begin n_fail++; $display("FAIL rst_pre_beat: got v=%b d=%h want v=1 d=11", m_valid, m_data); end
      #3 reset = 1'b1;
      #1;
      n_checks++; if ({m_valid, m_data, m_last} !== 10'd0) begin n_fail++; $display("FAIL rst_async_out: got v=%b d=%h l=%b want all 0", m_valid, m_data, m_last); end
      n_checks++; if ({grant, busy, s_ready} !== 9'd0) begin n_fail++; $display("FAIL rst_async_ctl: got grant=%b busy=%b s_ready=%b want 0", grant, busy, s_ready); end
      @(posedge clk); #1;
      reset = 1'b0; s_valid = 4'b0000;
      step();
      n_checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_release_idle: got grant=%b busy=%b want 0000/0", grant, busy); end
   endtask

   task automatic test_single;
      m_ready = 1'b1;
      s_valid = 4'b0100; set_lane(2, 8'hA1, 1'b0);
      #1;
      n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL single_c0_grant: got %b want 0000", grant); end
      step();
      n_checks++; if (grant !== 4'b0100 || busy !== 1'b1) begin n_fail++; $display("FAIL single_c1_grant: got %b busy=%b want 0100/1", grant, busy); end
      n_checks++; if (s_ready !== 4'b0100 || m_valid !== 1'b0) begin n_fail++; $display("FAIL single_c1_ready: got s_ready=%b m_valid=%b want 0100/0", s_ready, m_valid); end
      step();
      set_lane(2, 8'hA2, 1'b0); #1;
      n_checks++; if (m_valid !== 1'b1 || m_data !== 8'hA1 || m_last !== 1'b0) begin n_fail++; $display("FAIL single_c2_beat: got v=%b d=%h l=%b want 1/A1/0", m_valid, m_data, m_last); end
      step();
      set_lane(2, 8'hA3, 1'b1); #1;
      n_checks++; if (m_valid !== 1'b1 || m_data !== 8'hA2 || m_last !== 1'b0) begin n_fail++; $display("FAIL single_c3_beat: got v=%b d=%h l=%b want 1/A2/0", m_valid, m_data, m_last); end
      n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL single_c3_grant: got %b want 0100", grant); end
      step();
      s_valid = 4'b0000; #1;
      n_checks++; if (m_valid !== 1'b1 || m_data !== 8'hA3 || m_last !== 1'b1) begin n_fail++; $display("FAIL single_c4_beat: got v=%b d=%h l=%b want 1/A3/1", m_valid, m_data, m_last); end
      n_checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL single_c4_release: got grant=%b busy=%b want 0000/0", grant, busy); end
      step();
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL single_c5_drain: got m_valid=%b want 0", m_valid); end
   endtask

   // All four requesters hold 2-beat packets continuously. Each packet
   // occupies 3 cycles (2 locked + 1 idle) starting at cycle 1.
   task automatic test_round_robin;
      int          cnt [4];
      logic [3:0]  eg;
      logic        ev;
      logic [7:0]  ed;
      logic        el;
      int          p, b, req;
      do_reset();
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      for (int c = 0; c < 16; c++) begin
         s_valid = 4'b1111;
         for (int i = 0; i < 4; i++) set_lane(i, 8'(i*16 + cnt[i]), cnt[i] % 2 == 1);
         if (c == 0 || (c-1) % 3 == 2) eg = 4'b0000;
         else                          eg = 4'b0001 << (((c-1)/3) % 4);
         ev = (c >= 2) && ((c-2) % 3 < 2);
         ed = 8'h00; el = 1'b0;
         if (ev) begin
            p   = (c-2) / 3;
            req = p % 4;
            b   = (p/4)*2 + (c-2) % 3;
            ed  = 8'(req*16 + b);
            el  = (b % 2 == 1);
         end
         #1;
         n_checks++; if (grant !== eg || s_ready !== eg) begin n_fail++; $display("FAIL rr_grant c=%0d: got grant=%b s_ready=%b want %b", c, grant, s_ready, eg); end
         n_checks++; if (m_valid !== ev) begin n_fail++; $display("FAIL rr_valid c=%0d: got %b want %b", c, m_valid, ev); end
         if (ev) begin
            n_checks++; if (m_data !== ed || m_last !== el) begin n_fail++; $display("FAIL rr_beat c=%0d: got d=%h l=%b want d=%h l=%b", c, m_data, m_last, ed, el); end
         end
         step();
         for (int i = 0; i < 4; i++) if (eg[i]) cnt[i]++;
      end
      s_valid = 4'b0000;
   endtask

   task automatic test_backpressure;
      logic [7:0] got [$];
      logic       gl  [$];
      int         idx;
      logic [7:0] prev_d;
      logic       stall;
      logic       acc;
      do_reset();
      idx = 0; stall = 1'b0; prev_d = 8'h00;
      for (int c = 0; c < 40 && got.size() < 4; c++) begin
         m_ready = (c % 4 == 0) || (c % 4 == 3);
         s_valid = (idx < 4) ? 4'b0010 : 4'b0000;
         set_lane(1, 8'(8'h10 + idx), idx == 3);
         #1;
         if (stall) begin
            n_checks++; if (m_valid !== 1'b1 || m_data !== prev_d) begin n_fail++; $display("FAIL bp_hold c=%0d: got v=%b d=%h want v=1 d=%h", c, m_valid, m_data, prev_d); end
         end
         if (m_valid && !m_ready) begin
            n_checks++; if (s_ready[1] !== 1'b0) begin n_fail++; $display("FAIL bp_ready c=%0d: got s_ready=%b want bit1=0", c, s_ready); end
         end
         if (m_valid && m_ready) begin
            got.push_back(m_data);
            gl.push_back(m_last);
         end
         stall  = m_valid && !m_ready;
         prev_d = m_data;
         acc    = s_valid[1] && s_ready[1];
         step();
         if (acc) idx++;
      end
      m_ready = 1'b1;
      s_valid = 4'b0000;
      n_checks++; if (got.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d beats want 4", got.size()); end
      for (int k = 0; k < 4 && k < got.size(); k++) begin
         n_checks++; if (got[k] !== 8'(8'h10 + k) || gl[k] !== (k == 3)) begin n_fail++; $display("FAIL bp_order k=%0d: got d=%h l=%b want d=%h l=%b", k, got[k], gl[k], 8'(8'h10 + k), k == 3); end
      end
   endtask

   task automatic test_lock;
      m_ready = 1'b1;
      s_valid = 4'b0001; set_lane(0, 8'h50, 1'b0); set_lane(3, 8'h70, 1'b1);
      #1;
      n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL lock_c0: got %b want 0000", grant); end
      step();
      n_checks++; if (grant !== 4'b0001 || s_ready !== 4'b0001) begin n_fail++; $display("FAIL lock_c1: got grant=%b s_ready=%b want 0001", grant, s_ready); end
      step();
      s_valid = 4'b1000; #1;
      n_checks++; if (grant !== 4'b0001 || s_ready !== 4'b0001) begin n_fail++; $display("FAIL lock_c2_hold: got grant=%b s_ready=%b want 0001", grant, s_ready); end
      n_checks++; if (m_valid !== 1'b1 || m_data !== 8'h50) begin n_fail++; $display("FAIL lock_c2_beat: got v=%b d=%h want 1/50", m_valid, m_data); end
      step();
      n_checks++; if (grant !== 4'b0001 || s_ready[3] !== 1'b0 || m_valid !== 1'b0) begin n_fail++; $display("FAIL lock_c3_hold: got grant=%b s_ready=%b v=%b want 0001/bit3=0/0", grant, s_ready, m_valid); end
      step();
      n_checks++; if (grant !== 4'b0001 || busy !== 1'b1) begin n_fail++; $display("FAIL lock_c4_hold: got grant=%b busy=%b want 0001/1", grant, busy); end
      step();
      s_valid = 4'b1001; set_lane(0, 8'h51, 1'b1); #1;
      n_checks++; if (grant !== 4'b0001 || s_ready !== 4'b0001) begin n_fail++; $display("FAIL lock_c5_last: got grant=%b s_ready=%b want 0001", grant, s_ready); end
      step();
      s_valid = 4'b1000; #1;
      n_checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL lock_c6_release: got grant=%b busy=%b want 0000/0", grant, busy); end
      n_checks++; if (m_data !== 8'h51 || m_last !== 1'b1) begin n_fail++; $display("FAIL lock_c6_beat: got d=%h l=%b want 51/1", m_data, m_last); end
      step();
      n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL lock_c7_next: got %b want 1000", grant); end
      step();
      s_valid = 4'b0000; #1;
      n_checks++; if (grant !== 4'b0000 || m_valid !== 1'b1 || m_data !== 8'h70 || m_last !== 1'b1) begin n_fail++; $display("FAIL lock_c8_r3: got grant=%b v=%b d=%h l=%b want 0000/1/70/1", grant, m_valid, m_data, m_last); end
      step();
   endtask

   task automatic test_reset_mid_packet;
      m_ready = 1'b1;
      // Single-beat packet from requester 1 moves the pointer to 2.
      s_valid = 4'b0010; set_lane(1, 8'h31, 1'b1);
      #1;
      n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL mid_c0: got %b want 0000", grant); end
      step();
      n_checks++; if (grant !== 4'b0010 || busy !== 1'b1 || s_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_c1_single: got grant=%b busy=%b s_ready=%b want 0010/1/0010", grant, busy, s_ready); end
      step();
      s_valid = 4'b0100; set_lane(2, 8'h20, 1'b0); #1;
      n_checks++; if (grant !== 4'b0000 || m_valid !== 1'b1 || m_data !== 8'h31 || m_last !== 1'b1) begin n_fail++; $display("FAIL mid_c2_single: got grant=%b v=%b d=%h l=%b want 0000/1/31/1", grant, m_valid, m_data, m_last); end
      step();
      n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL mid_c3_grant: got %b want 0100", grant); end
      step();
      set_lane(2, 8'h21, 1'b0); #1;
      n_checks++; if (m_data !== 8'h20 || m_last !== 1'b0) begin n_fail++; $display("FAIL mid_c4_beat: got d=%h l=%b want 20/0", m_data, m_last); end
      step();
      set_lane(2, 8'h22, 1'b0); #1;
      n_checks++; if (m_data !== 8'h21 || m_valid !== 1'b1) begin n_fail++; $display("FAIL mid_c5_beat: got v=%b d=%h want 1/21", m_valid, m_data); end
      #3 reset = 1'b1;
      #1;
      n_checks++; if ({m_valid, m_data, m_last} !== 10'd0) begin n_fail++; $display("FAIL mid_rst_out: got v=%b d=%h l=%b want all 0", m_valid, m_data, m_last); end
      n_checks++; if ({grant, busy, s_ready} !== 9'd0) begin n_fail++; $display("FAIL mid_rst_ctl: got grant=%b busy=%b s_ready=%b want 0", grant, busy, s_ready); end
      @(posedge clk); #1;
      reset = 1'b0;
      s_valid = 4'b0101; set_lane(0, 8'h40, 1'b1); set_lane(2, 8'h20, 1'b0);
      #1;
      n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL mid_post_idle: got %b want 0000", grant); end
      step();
      n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL mid_post_ptr0: got %b want 0001", grant); end
      s_valid = 4'b0000;
      step(); step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_lock();
      test_reset_mid_packet();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/axis_rr_arbiter_4to1.md
# axis_rr_arbiter_4to1

Four-input, packet-locked round-robin arbiter that shares a single 8-bit AXI-Stream sink, such as the 8-bit AXI holding register, between four upstream requesters. It grants one requester at a time and holds the grant until that requester's Tlast beat is accepted. Accepted beats are forwarded through one output register stage. It sits between the stream sources and the downstream register, and produces the valid/ready/last handshake the register consumes.

## Interface
- DATA_W, 8, data width of every stream port.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- s_valid  input  4  per-requester valid; bit i belongs to requester i.
- s_data  input  4*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
- s_last  input  4  per-requester end-of-packet flag.
- s_ready  output  4  per-requester ready; at most one bit high (one-hot or zero).
- m_valid  output  1  downstream valid.
- m_data  output  DATA_W  downstream data.
- m_last  output  1  downstream end-of-packet.
- m_ready  input  1  downstream ready.
- grant  output  4  one-hot registered grant; zero when idle.
- busy  output  1  high while a packet is locked (state LOCK).

## Operation
- Reset values:
  - m_valid=0, m_data=0, m_last=0, grant=0, busy=0, s_ready=0.
  - State is IDLE.
  - Round-robin pointer ptr=0, so requester 0 has highest priority first.
- State machine, two states:
  - IDLE: if any s_valid bit is high, select the first requester with s_valid=1, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
    - Register that requester's index, set grant one-hot and busy=1, go to LOCK.
    - If no s_valid bit is high, stay in IDLE with grant=0.
  - LOCK: s_ready[g] = !m_valid || m_ready, where g is the granted index; all other s_ready bits are 0.
    - A beat is accepted when s_valid[g] && s_ready[g].
    - If the accepted beat has s_last[g]=1, go to IDLE on the same edge, clear grant and busy, and set ptr=(g+1) mod 4.
- Output register:
  - On beat accept, load m_data=s_data[g], m_last=s_last[g], m_valid=1.
  - Else, if m_valid && m_ready, clear m_valid to 0.
  - m_data and m_last hold their values when not loaded.
- Requests from non-granted requesters are ignored while in LOCK; their s_ready stays 0 and their data is never sampled.
- Deasserting s_valid mid-packet does not release the lock; only an accepted last beat releases it.
- s_valid of a non-granted requester may toggle freely; no requirement is placed on it.
- Single-beat packets (s_last=1 on the first beat) are legal: lock for one accepted beat, then release.
- Reset mid-packet: the output register and grant clear immediately, and the partially sent packet is dropped without emitting m_last. Sources must restart their packets after reset.

## Timing
- Arbitration latency:
  - s_valid rises in IDLE at cycle 0; grant and busy are high at cycle 1.
  - s_ready[g] is high in cycle 1 if the output register is free; the first beat is accepted at the end of cycle 1.
  - m_valid is high in cycle 2.
- Throughput:
  - One beat per cycle while m_ready=1.
  - s_ready[g] depends combinationally on m_ready (pass-through backpressure, no skid buffer).
- Packet boundary: the edge that accepts the last beat also enters IDLE. At least one idle cycle (grant=0) separates consecutive packets, even from the same requester.
- Fairness: after requester i finishes, it has lowest priority for the next arbitration. With all four requesting continuously, grants follow 0,1,2,3,0,...
- m_valid, m_data and m_last are fully registered. m_data stays stable while m_valid=1 && m_ready=0.

## Test plan
- Reset: assert reset asynchronously mid-cycle -> all outputs 0 immediately; after release, grant=0 until a request arrives.
- Single requester: requester 2 sends a 3-beat packet 0xA1, 0xA2, 0xA3 (last on 0xA3) with m_ready=1 -> grant=4'b0100 from cycle 1; m_data shows A1, A2, A3 in cycles 2-4; m_last=1 only with A3; grant=0 in cycle 4.
- Round robin: all four requesters hold 2-beat packets continuously -> grant order 0,1,2,3,0 with exactly one idle cycle between packets; no interleaving of beats.
- Backpressure: requester 1 sends 4 beats 0x10-0x13 while m_ready toggles 1,0,0,1,... -> s_ready[1] low whenever m_valid=1 && m_ready=0; every beat appears exactly once, in order, with m_data held stable during stalls.
- Lock and lock release: requester 0 is locked, deasserts s_valid for 3 cycles mid-packet while requester 3 asserts s_valid -> grant stays 4'b0001; after 0's last beat, requester 3 is granted next.
- Reset mid-packet: reset asserted after 2 of 4 beats -> m_valid=0 and grant=0 immediately; after release, requester 0 wins first arbitration because ptr=0.
